// File: rtl/piso_serializer.sv
// Parallel-in/serial-out stage: takes WIDTH-bit words on a valid/ready
// handshake and emits one bit per clk with no gaps between back-to-back words.
module piso_serializer #(
  parameter int   WIDTH     = 8,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             prtx,
  output logic             prtx_valid,
  output logic             busy,
  output logic             frame_done,
  output logic [15:0]      frame_count
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-2:0] sreg;
  logic [WIDTH-2:0] sreg_load;
  logic             first_bit;
  logic             at_last;
  logic             accept;

  // Handshake: a word transfers on a clk edge where din_valid && din_ready.
  // din_ready is combinational and is held low while rst is asserted.
  assign at_last    = (state == SHIFT) && (cnt == LAST);
  assign din_ready  = !rst && ((state == IDLE) || at_last);
  assign accept     = din_valid && din_ready;
  assign busy       = (state == SHIFT);
  assign frame_done = at_last;

  // sreg holds the remaining bits in send order; its top bit goes out next.
  always_comb begin
    sreg_load = '0;
    first_bit = 1'b0;
    if (MSB_FIRST) begin
      first_bit = din[WIDTH-1];
      sreg_load = din[WIDTH-2:0];
    end else begin
      first_bit = din[0];
      for (int i = 0; i < WIDTH - 1; i++) begin
        sreg_load[WIDTH-2-i] = din[i+1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      sreg        <= '0;
      prtx        <= IDLE_BIT;
      prtx_valid  <= 1'b0;
      frame_count <= 16'd0;
    end else if (accept) begin
      state       <= SHIFT;
      cnt         <= '0;
      sreg        <= sreg_load;
      prtx        <= first_bit;
      prtx_valid  <= 1'b1;
      frame_count <= frame_count + 16'd1;
    end else if (state == SHIFT) begin
      if (at_last) begin
        state      <= IDLE;
        prtx       <= IDLE_BIT;
        prtx_valid <= 1'b0;
      end else begin
        prtx <= sreg[WIDTH-2];
        sreg <= sreg << 1;
        cnt  <= cnt + 1'b1;
      end
    end
  end

endmodule
